// File: rtl/arm_sequence_ctrl.sv
// Motion-pattern playback engine: fetches NUM_JOINTS ROM words per frame,
// publishes each complete frame atomically on joint_pos, then holds it for
// STEP_CYCLES clocks (measured from the frame's first ROM read) before
// fetching the next frame. Supports start, stop and looped playback.
module arm_sequence_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 8,
   parameter int NUM_JOINTS  = 4,
   parameter int STEP_CYCLES = 50000000,
   parameter int ROM_LATENCY = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             stop,
   input  logic                             loop_en,
   input  logic [ADDR_WIDTH-1:0]            base_addr,
   input  logic [ADDR_WIDTH-1:0]            num_frames,
   output logic                             rom_ce,
   output logic                             rom_read_enable,
   output logic [ADDR_WIDTH-1:0]            rom_address,
   input  logic [DATA_WIDTH-1:0]            rom_data,
   output logic [NUM_JOINTS*DATA_WIDTH-1:0] joint_pos,
   output logic                             frame_valid,
   output logic [ADDR_WIDTH-1:0]            frame_idx,
   output logic                             busy,
   output logic                             done
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, HOLD} state_t;

   localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES + 1) : 1;
   localparam int JW = (NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1;
   localparam int LW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY + 1) : 1;
   localparam logic [TW-1:0] STEP_LOAD = TW'(STEP_CYCLES - 1);
   localparam logic [JW-1:0] LAST_JOINT = JW'(NUM_JOINTS - 1);

   state_t                  state_r;
   logic [ADDR_WIDTH-1:0]   base_r;
   logic [ADDR_WIDTH-1:0]   num_r;
   logic [ADDR_WIDTH-1:0]   frame_r;
   logic [JW-1:0]           joint_r;
   logic [TW-1:0]           timer_r;
   logic [LW-1:0]           wait_r;
   logic                    wrap_r;
   logic [DATA_WIDTH-1:0]   shadow_r [NUM_JOINTS];

   logic [NUM_JOINTS*DATA_WIDTH-1:0] publish_s;
   logic [ADDR_WIDTH-1:0]            next_frame_s;
   logic                             last_frame_s;

   // ROM address of a given joint within a given frame, wrapping mod 2^ADDR_WIDTH
   function automatic logic [ADDR_WIDTH-1:0] rom_addr_of(
      input logic [ADDR_WIDTH-1:0] base,
      input logic [ADDR_WIDTH-1:0] frame,
      input logic [JW-1:0]         joint
   );
      rom_addr_of = base + ADDR_WIDTH'(frame * NUM_JOINTS) + ADDR_WIDTH'(joint);
   endfunction

   // Assemble the frame to publish: earlier joints from shadows, last joint straight from the ROM
   always_comb begin
      publish_s = {(NUM_JOINTS*DATA_WIDTH){1'b0}};
      for (int j = 0; j < NUM_JOINTS; j++) begin
         if (j == NUM_JOINTS - 1) begin
            publish_s[j*DATA_WIDTH +: DATA_WIDTH] = rom_data;
         end else begin
            publish_s[j*DATA_WIDTH +: DATA_WIDTH] = shadow_r[j];
         end
      end
   end

   // Frame bookkeeping: is this the last frame, and which frame comes after the hold
   always_comb begin
      last_frame_s = (frame_r == (num_r - ADDR_WIDTH'(1)));
      if (wrap_r) begin
         next_frame_s = {ADDR_WIDTH{1'b0}};
      end else begin
         next_frame_s = frame_r + ADDR_WIDTH'(1);
      end
   end

   // Playback FSM with registered ROM strobes and published outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r         <= IDLE;
         base_r          <= {ADDR_WIDTH{1'b0}};
         num_r           <= {ADDR_WIDTH{1'b0}};
         frame_r         <= {ADDR_WIDTH{1'b0}};
         joint_r         <= {JW{1'b0}};
         timer_r         <= {TW{1'b0}};
         wait_r          <= {LW{1'b0}};
         wrap_r          <= 1'b0;
         for (int j = 0; j < NUM_JOINTS; j++) shadow_r[j] <= {DATA_WIDTH{1'b0}};
         rom_ce          <= 1'b0;
         rom_read_enable <= 1'b0;
         rom_address     <= {ADDR_WIDTH{1'b0}};
         joint_pos       <= {(NUM_JOINTS*DATA_WIDTH){1'b0}};
         frame_valid     <= 1'b0;
         frame_idx       <= {ADDR_WIDTH{1'b0}};
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-asserted below
         rom_ce          <= 1'b0;
         rom_read_enable <= 1'b0;
         frame_valid     <= 1'b0;
         done            <= 1'b0;
         if (timer_r != {TW{1'b0}}) begin
            timer_r <= timer_r - TW'(1);
         end else begin
            timer_r <= timer_r;
         end

         if (state_r != IDLE && stop) begin
            // Abort: drop partial frame, keep the last published one on the outputs
            state_r <= IDLE;
            busy    <= 1'b0;
            joint_r <= {JW{1'b0}};
         end else begin
            case (state_r)
               IDLE: begin
                  // busy lingers one cycle after a done pulse; a start then is still ignored
                  if (start && (num_frames != {ADDR_WIDTH{1'b0}}) && !busy) begin
                     base_r          <= base_addr;
                     num_r           <= num_frames;
                     frame_r         <= {ADDR_WIDTH{1'b0}};
                     joint_r         <= {JW{1'b0}};
                     wrap_r          <= 1'b0;
                     timer_r         <= STEP_LOAD;
                     state_r         <= ISSUE;
                     busy            <= 1'b1;
                     rom_ce          <= 1'b1;
                     rom_read_enable <= 1'b1;
                     rom_address     <= base_addr;
                  end else begin
                     busy <= 1'b0;
                  end
               end
               ISSUE: begin
                  if (ROM_LATENCY == 1) begin
                     state_r <= CAPTURE;
                  end else begin
                     wait_r  <= LW'(ROM_LATENCY - 2);
                     state_r <= WAIT;
                  end
               end
               WAIT: begin
                  if (wait_r == {LW{1'b0}}) begin
                     state_r <= CAPTURE;
                  end else begin
                     wait_r <= wait_r - LW'(1);
                  end
               end
               CAPTURE: begin
                  shadow_r[joint_r] <= rom_data;
                  if (joint_r != LAST_JOINT) begin
                     joint_r         <= joint_r + JW'(1);
                     state_r         <= ISSUE;
                     rom_ce          <= 1'b1;
                     rom_read_enable <= 1'b1;
                     rom_address     <= rom_addr_of(base_r, frame_r, joint_r + JW'(1));
                  end else begin
                     joint_pos   <= publish_s;
                     frame_valid <= 1'b1;
                     frame_idx   <= frame_r;
                     if (last_frame_s && !loop_en) begin
                        done    <= 1'b1;
                        state_r <= IDLE;
                     end else begin
                        wrap_r  <= last_frame_s;
                        state_r <= HOLD;
                     end
                  end
               end
               HOLD: begin
                  if (timer_r == {TW{1'b0}}) begin
                     frame_r         <= next_frame_s;
                     joint_r         <= {JW{1'b0}};
                     timer_r         <= STEP_LOAD;
                     state_r         <= ISSUE;
                     rom_ce          <= 1'b1;
                     rom_read_enable <= 1'b1;
                     rom_address     <= rom_addr_of(base_r, next_frame_s, {JW{1'b0}});
                  end else begin
                     state_r <= HOLD;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_arm_sequence_ctrl.sv
// Directed bench for arm_sequence_ctrl with a 1-cycle ROM returning addr+0x10.
module tb_arm_sequence_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, stop, loop_en;
   logic [7:0]  base_addr, num_frames;
   logic        rom_ce, rom_read_enable;
   logic [7:0]  rom_address;
   logic [7:0]  rom_data = 8'h00;
   logic [31:0] joint_pos;
   logic        frame_valid, done, busy;
   logic [7:0]  frame_idx;

   int checks   = 0;
   int failures = 0;

   arm_sequence_ctrl #(
      .DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_JOINTS(4), .STEP_CYCLES(20), .ROM_LATENCY(1)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
      .base_addr(base_addr), .num_frames(num_frames),
      .rom_ce(rom_ce), .rom_read_enable(rom_read_enable), .rom_address(rom_address),
      .rom_data(rom_data), .joint_pos(joint_pos), .frame_valid(frame_valid),
      .frame_idx(frame_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // ROM model: one cycle of read latency, mem[a] = a + 0x10
   always @(posedge clk) begin
      if (rom_ce && rom_read_enable) rom_data <= rom_address + 8'h10;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check four ISSUE/CAPTURE pairs starting at the current ISSUE cycle; ends on the publish cycle
   task automatic fetch_frame(input string tag, input logic [7:0] first);
      logic [7:0] a;
      for (int j = 0; j < 4; j++) begin
         a = first + 8'(j);
         chk({tag, "_ce"},   32'(rom_ce), 32'd1);
         chk({tag, "_re"},   32'(rom_read_enable), 32'd1);
         chk({tag, "_addr"}, 32'(rom_address), 32'(a));
         step();
         chk({tag, "_ce_off"}, 32'(rom_ce), 32'd0);
         step();
      end
   endtask

   // Advance until the next ROM read; bounded, returns number of cycles advanced
   task automatic wait_issue(output int n);
      n = 0;
      while (!rom_ce && n < 100) begin
         step();
         n++;
      end
   endtask

   task automatic kick(input logic [7:0] base, input logic [7:0] nf, input logic lp);
      base_addr = base; num_frames = nf; loop_en = lp; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      int n;
      logic seen;
      rst = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
      base_addr = 8'h00; num_frames = 8'h00;
      #3;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ce", 32'(rom_ce), 32'd0);
      chk("rst_pos", joint_pos, 32'd0);
      chk("rst_fv", 32'(frame_valid), 32'd0);
      chk("rst_idx", 32'(frame_idx), 32'd0);
      @(posedge clk); #1; rst = 1'b1;
      step();

      // Two frames, no loop: exact cycle timing
      kick(8'h00, 8'd2, 1'b0);
      chk("t1_busy", 32'(busy), 32'd1);
      fetch_frame("t1_f0", 8'h00);
      chk("t1_fv0", 32'(frame_valid), 32'd1);
      chk("t1_pos0", joint_pos, 32'h13121110);
      chk("t1_idx0", 32'(frame_idx), 32'd0);
      chk("t1_done0", 32'(done), 32'd0);
      step();
      chk("t1_fv_pulse", 32'(frame_valid), 32'd0);
      wait_issue(n);
      chk("t1_hold_len", 32'(n), 32'd11);
      fetch_frame("t1_f1", 8'h04);
      chk("t1_fv1", 32'(frame_valid), 32'd1);
      chk("t1_pos1", joint_pos, 32'h17161514);
      chk("t1_idx1", 32'(frame_idx), 32'd1);
      chk("t1_done1", 32'(done), 32'd1);
      chk("t1_busy_at_done", 32'(busy), 32'd1);
      step();
      chk("t1_busy_end", 32'(busy), 32'd0);
      chk("t1_done_pulse", 32'(done), 32'd0);
      chk("t1_pos_hold", joint_pos, 32'h17161514);

      // Address wrap-around
      step();
      kick(8'hFE, 8'd1, 1'b0);
      fetch_frame("t2", 8'hFE);
      chk("t2_pos", joint_pos, 32'h11100F0E);
      chk("t2_done", 32'(done), 32'd1);
      step(); step();

      // Looping: third fetch restarts at frame 0, never done
      kick(8'h00, 8'd2, 1'b1);
      fetch_frame("t3_f0", 8'h00);
      chk("t3_idx0", 32'(frame_idx), 32'd0);
      wait_issue(n);
      fetch_frame("t3_f1", 8'h04);
      chk("t3_idx1", 32'(frame_idx), 32'd1);
      chk("t3_done1", 32'(done), 32'd0);
      wait_issue(n);
      chk("t3_hold_len", 32'(n), 32'd12);
      fetch_frame("t3_f2", 8'h00);
      chk("t3_idx2", 32'(frame_idx), 32'd0);
      chk("t3_done2", 32'(done), 32'd0);
      chk("t3_busy", 32'(busy), 32'd1);
      stop = 1'b1; step(); stop = 1'b0;
      chk("t3_stop_busy", 32'(busy), 32'd0);
      step();

      // Stop during the ISSUE of joint 2 in frame 1
      kick(8'h00, 8'd2, 1'b0);
      fetch_frame("t4_f0", 8'h00);
      wait_issue(n);
      step(); step(); step(); step();
      chk("t4_j2_ce", 32'(rom_ce), 32'd1);
      chk("t4_j2_addr", 32'(rom_address), 32'h06);
      stop = 1'b1; step(); stop = 1'b0;
      chk("t4_ce", 32'(rom_ce), 32'd0);
      chk("t4_busy", 32'(busy), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         seen = seen | frame_valid | done | rom_ce | busy;
         step();
      end
      chk("t4_quiet", 32'(seen), 32'd0);
      chk("t4_pos", joint_pos, 32'h13121110);
      chk("t4_idx", 32'(frame_idx), 32'd0);

      // Asynchronous reset during HOLD
      kick(8'h20, 8'd2, 1'b0);
      fetch_frame("t5_f0", 8'h20);
      step(); step(); step();
      #2 rst = 1'b0;
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_pos", joint_pos, 32'd0);
      chk("t5_idx", 32'(frame_idx), 32'd0);
      chk("t5_ce", 32'(rom_ce), 32'd0);
      step(); rst = 1'b1; step();
      kick(8'h20, 8'd1, 1'b0);
      fetch_frame("t5_replay", 8'h20);
      chk("t5_pos2", joint_pos, 32'h33323130);
      chk("t5_done", 32'(done), 32'd1);
      step(); step();

      // Start while busy is ignored; base/num changes have no effect
      kick(8'h00, 8'd2, 1'b0);
      fetch_frame("t6_f0", 8'h00);
      base_addr = 8'h80; num_frames = 8'd5; start = 1'b1;
      step();
      start = 1'b0;
      wait_issue(n);
      chk("t6_hold_len", 32'(n), 32'd11);
      fetch_frame("t6_f1", 8'h04);
      chk("t6_done", 32'(done), 32'd1);
      step(); step();

      // num_frames = 0 is ignored
      kick(8'h00, 8'd0, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seen = seen | busy | rom_ce;
         step();
      end
      chk("t7_idle", 32'(seen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arm_sequence_ctrl.md
Name: arm_sequence_ctrl

Overview:
- Playback controller that sequences the motion-pattern ROM.
- Walks the ROM frame by frame. A frame is NUM_JOINTS consecutive bytes, one target position per arm joint.
- Publishes each complete frame atomically to the servo drivers, then holds it for a programmable step period before fetching the next.
- Replaces manual one-shot stepping of ROM addresses with a start/stop/loop playback engine.

Parameters:
- DATA_WIDTH, 8, width of one ROM word / joint position.
- ADDR_WIDTH, 8, ROM address width.
- NUM_JOINTS, 4, words per frame (joints driven).
- STEP_CYCLES, 50000000, clk cycles between consecutive frame fetch starts (1 Hz at 50 MHz).
- ROM_LATENCY, 1, cycles from read issue to valid rom_data (≥1).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous, active-low reset.
- start, in, 1, single-cycle request to begin playback.
- stop, in, 1, abort playback.
- loop_en, in, 1, restart from frame 0 after the last frame.
- base_addr, in, ADDR_WIDTH, ROM address of frame 0 / joint 0.
- num_frames, in, ADDR_WIDTH, frames in the sequence.
- rom_ce, out, 1, ROM chip enable.
- rom_read_enable, out, 1, ROM read strobe.
- rom_address, out, ADDR_WIDTH, ROM address.
- rom_data, in, DATA_WIDTH, ROM read data.
- joint_pos, out, NUM_JOINTS*DATA_WIDTH, published frame; joint j at [j*DATA_WIDTH +: DATA_WIDTH].
- frame_valid, out, 1, 1-cycle pulse when joint_pos updates.
- frame_idx, out, ADDR_WIDTH, index of the last published frame.
- busy, out, 1, playback active.
- done, out, 1, 1-cycle pulse at natural completion.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state IDLE, step timer 0, shadow registers 0.
- States: IDLE, ISSUE, WAIT, CAPTURE, HOLD.
- IDLE:
  - start=1 with num_frames≠0 latches base_addr and num_frames, clears frame and joint counters, loads the step timer, and goes to ISSUE.
  - start with num_frames=0 is ignored.
- ISSUE (1 cycle): rom_ce=rom_read_enable=1; rom_address = base + frame*NUM_JOINTS + joint, truncated mod 2^ADDR_WIDTH (wrap-around).
- WAIT: ROM_LATENCY-1 cycles (skipped when ROM_LATENCY=1).
- CAPTURE: rom_data is sampled into shadow[joint] at the end of the cycle that is ROM_LATENCY cycles after ISSUE. Each joint therefore costs 1+ROM_LATENCY cycles.
  - joint<NUM_JOINTS-1: joint+1, go to ISSUE.
  - Last joint: next cycle, joint_pos ← all shadows simultaneously, frame_valid=1, frame_idx=frame.
    - If this was the last frame and loop_en=0: done=1 in the same cycle, then IDLE (busy falls the following cycle).
    - Otherwise go to HOLD.
- rom_ce and rom_read_enable are high only in ISSUE cycles.
- Step timer:
  - Loaded with STEP_CYCLES-1 at the first ISSUE of every frame; decrements every cycle.
  - HOLD exits when the timer reaches 0: frame+1, or frame=0 if the last frame was just published with loop_en=1 (sampled at publish); joint=0; go to ISSUE.
  - If STEP_CYCLES < fetch time, HOLD exits immediately; the period equals the fetch time.
- busy=1 in every state except IDLE.
- stop=1 in any non-IDLE state: next cycle IDLE, busy=0, rom_ce=0. joint_pos and frame_idx retain the last published frame; no frame_valid or done. Partial shadows are discarded.
- stop has priority over a simultaneous frame publish; that frame is not published.
- start while busy is ignored.
- base_addr and num_frames changes while busy have no effect.
- joint_pos holds its value indefinitely between frame_valid pulses.

Test Plan:
Bench settings: NUM_JOINTS=4, ROM_LATENCY=1, STEP_CYCLES=20, ROM model mem[a]=a+0x10 (mod 256); start sampled at cycle 0.
- base=0x00, num_frames=2, loop_en=0, start → reads 0x00–0x03 at cycles 1,3,5,7; cycle 9: frame_valid=1, joint_pos=0x13121110, frame_idx=0. Next ISSUE at cycle 21, address 0x04; joint_pos=0x17161514 with done=1 at cycle 29; busy=0 from cycle 30.
- base=0xFE, num_frames=1 → rom_address sequence 0xFE, 0xFF, 0x00, 0x01; joint_pos=0x11100F0E; done pulse.
- loop_en=1, num_frames=2 → the third fetch reads 0x00–0x03, frame_idx returns to 0, done never asserts, busy stays 1.
- stop pulsed during the ISSUE of joint 2 in frame 1 → rom_ce=0 and busy=0 the next cycle; joint_pos stays 0x13121110; no frame_valid, no done.
- rst driven low mid-HOLD → all outputs 0 without a clock edge; after release, start replays from address base+0.
- start while busy → no restart, timing unchanged; start with num_frames=0 → stays IDLE, busy=0, no ROM access.
